// File: rtl/decrypt_round_key_feeder.sv
// AES-128 inverse-cipher key feeder: expands a cipher key into 11 round keys,
// then streams them from round 10 down to round 0 over valid/ready, with replay.

package AESDefinitions;
  typedef logic [127:0] roundKey_t;

  localparam logic [0:15][127:0] SBOX_ROWS = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROWS[b[7:4]];
    return row[8*(15-b[3:0]) +: 8];
  endfunction
endpackage

module decrypt_round_key_feeder
  import AESDefinitions::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       keyValid,
  input  roundKey_t  key,
  output logic       keyReady,
  input  logic       replay,
  output logic       rkValid,
  input  logic       rkReady,
  output roundKey_t  roundKey,
  output logic [3:0] rkIndex,
  output logic       rkLast
);
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       have_q, have_d;
  logic       vld_q, vld_d;
  roundKey_t  rk_q, rk_d;
  logic [3:0] idx_q, idx_d;
  logic       last_q, last_d;

  roundKey_t  buf_q [11];
  logic       buf_we;
  logic [3:0] buf_wa;
  roundKey_t  buf_wd;

  roundKey_t  prev_rk, next_rk;
  logic [7:0] rcon;
  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, t;

  // In EXPAND this is the previous round key; in EMIT it is the next one to send.
  assign prev_rk = buf_q[cnt_q - 4'd1];

  always_comb begin
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    {w0, w1, w2, w3} = prev_rk;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    w4 = w0 ^ t;
    w5 = w1 ^ w4;
    w6 = w2 ^ w5;
    w7 = w3 ^ w6;
    next_rk = {w4, w5, w6, w7};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    have_d   = have_q;
    vld_d    = vld_q;
    rk_d     = rk_q;
    idx_d    = idx_q;
    last_d   = last_q;
    buf_we   = 1'b0;
    buf_wa   = cnt_q;
    buf_wd   = next_rk;
    keyReady = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (keyValid) begin
          buf_we  = 1'b1;
          buf_wa  = 4'd0;
          buf_wd  = key;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end else if (replay && have_q) begin
          cnt_d   = 4'd10;
          state_d = EMIT;
          vld_d   = 1'b1;
          rk_d    = buf_q[10];
          idx_d   = 4'd10;
          last_d  = 1'b0;
        end
      end
      EXPAND: begin
        buf_we = 1'b1;
        if (cnt_q == 4'd10) begin
          // Round 10 goes straight to the output register as it is written.
          have_d  = 1'b1;
          state_d = EMIT;
          vld_d   = 1'b1;
          rk_d    = next_rk;
          idx_d   = 4'd10;
          last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      EMIT: begin
        if (rkReady) begin
          if (cnt_q != 4'd0) begin
            cnt_d  = cnt_q - 4'd1;
            rk_d   = prev_rk;
            idx_d  = cnt_q - 4'd1;
            last_d = (cnt_q == 4'd1);
          end else begin
            state_d = IDLE;
            vld_d   = 1'b0;
            rk_d    = '0;
            idx_d   = 4'd0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      have_q  <= 1'b0;
      vld_q   <= 1'b0;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      have_q  <= have_d;
      vld_q   <= vld_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Key storage is not reset; have_q gates every read path.
  always_ff @(posedge clock) begin
    if (buf_we) buf_q[buf_wa] <= buf_wd;
  end

  assign rkValid  = vld_q;
  assign roundKey = rk_q;
  assign rkIndex  = idx_q;
  assign rkLast   = last_q;
endmodule

// File: tb/tb_decrypt_round_key_feeder.sv
// Scoreboard bench for decrypt_round_key_feeder: stimulus pushes expected round
// keys, a negedge monitor pops and compares on every presented round key.

module tb_decrypt_round_key_feeder;
  logic         clock = 1'b0;
  logic         reset, keyValid, replay, rkReady;
  logic         keyReady, rkValid, rkLast;
  logic [127:0] key, roundKey;
  logic [3:0]   rkIndex;

  always #5 clock = ~clock;

  decrypt_round_key_feeder dut (
    .clock(clock), .reset(reset), .keyValid(keyValid), .key(key),
    .keyReady(keyReady), .replay(replay), .rkValid(rkValid), .rkReady(rkReady),
    .roundKey(roundKey), .rkIndex(rkIndex), .rkLast(rkLast)
  );

  typedef struct {
    logic [127:0] k;
    logic [3:0]   idx;
    bit           chk_key;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // FIPS-197 A.1 schedule, index = round number
  logic [127:0] K1 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6 };
  logic [127:0] K2_0  = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] K2_1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  logic [127:0] K2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_k1();
    for (int i = 10; i >= 0; i--) sb.push_back('{K1[i], 4'(i), 1'b1});
  endtask

  task automatic push_k2();
    for (int i = 10; i >= 0; i--) begin
      exp_t e;
      e.idx = 4'(i);
      e.chk_key = (i == 10 || i == 1 || i == 0);
      e.k = (i == 10) ? K2_10 : (i == 1) ? K2_1 : K2_0;
      sb.push_back(e);
    end
  endtask

  // Called at posedge+1 in IDLE; returns at T+11 with the first round key up.
  task automatic send_key(input logic [127:0] k);
    keyValid = 1'b1;
    key = k;
    @(posedge clock); #1;
    keyValid = 1'b0;
    replay = 1'b0;
    chk("keyready_low", 128'(keyReady), 128'(0));
    chk("expand_no_valid", 128'(rkValid), 128'(0));
    repeat (9) @(posedge clock);
    #1;
    chk("valid_at_t10", 128'(rkValid), 128'(0));
    @(posedge clock); #1;
    chk("valid_at_t11", 128'(rkValid), 128'(1));
    chk("first_idx", 128'(rkIndex), 128'(10));
  endtask

  task automatic wait_idle(input bit bp);
    int n = 0;
    while (!keyReady && n < 400) begin
      rkReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clock); #1;
      n++;
    end
    rkReady = 1'b1;
    chk("idle_reached", 128'(keyReady), 128'(1));
    if (!bp) chk("stream_cycles", 128'(n), 128'(11));
    chk("sb_drained", 128'(sb.size()), 128'(0));
  endtask

  task automatic pulse_replay();
    replay = 1'b1;
    @(posedge clock); #1;
    replay = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t         e;
    bit           stall = 1'b0;
    logic [127:0] s_rk;
    logic [3:0]   s_idx;
    logic         s_last;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 128'(rkValid), 128'(1));
          chk("stall_key", roundKey, s_rk);
          chk("stall_idx", 128'(rkIndex), 128'(s_idx));
          chk("stall_last", 128'(rkLast), 128'(s_last));
        end
        if (rkValid) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rk: got idx %0d key %h, expected no transfer", rkIndex, roundKey);
          end else begin
            e = sb[0];
            chk("rk_idx", 128'(rkIndex), 128'(e.idx));
            if (e.chk_key) chk("rk_key", roundKey, e.k);
            chk("rk_last", 128'(rkLast), 128'(e.idx == 4'd0));
            if (rkReady) void'(sb.pop_front());
          end
          stall  = !rkReady;
          s_rk   = roundKey;
          s_idx  = rkIndex;
          s_last = rkLast;
        end else begin
          chk("idle_outputs_zero", {rkIndex, rkLast, roundKey[122:0]} | 128'(roundKey[127:123]), 128'(0));
          stall = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; keyValid = 1'b0; replay = 1'b0; rkReady = 1'b1; key = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_keyready", 128'(keyReady), 128'(1));
    chk("rst_rkvalid", 128'(rkValid), 128'(0));
    chk("rst_roundkey", roundKey, 128'(0));
    chk("rst_rkindex", 128'(rkIndex), 128'(0));
    chk("rst_rklast", 128'(rkLast), 128'(0));

    // replay with no stored key is ignored
    pulse_replay();
    repeat (3) begin
      chk("replay_nokey", 128'(rkValid), 128'(0));
      @(posedge clock); #1;
    end

    // FIPS key, full-speed stream
    push_k1();
    send_key(K1[0]);
    wait_idle(1'b0);

    // replay re-streams the stored schedule one cycle after the request
    push_k1();
    pulse_replay();
    chk("replay_valid", 128'(rkValid), 128'(1));
    chk("replay_idx", 128'(rkIndex), 128'(10));
    wait_idle(1'b0);

    // second key
    push_k2();
    send_key(K2_0);
    wait_idle(1'b0);

    // backpressure
    push_k1();
    send_key(K1[0]);
    wait_idle(1'b1);

    // keyValid and replay together: key wins and expansion runs
    push_k2();
    replay = 1'b1;
    send_key(K2_0);
    wait_idle(1'b0);

    // keyValid during EMIT is ignored
    push_k1();
    send_key(K1[0]);
    keyValid = 1'b1;
    key = K2_0;
    wait_idle(1'b0);
    keyValid = 1'b0;

    // buffer untouched by that key: replay still gives K1; reset at idx5
    push_k1();
    pulse_replay();
    n = 0;
    while (rkIndex != 4'd5 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("reached_idx5", 128'(rkIndex), 128'(5));
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    chk("midrst_rkvalid", 128'(rkValid), 128'(0));
    chk("midrst_keyready", 128'(keyReady), 128'(1));
    chk("midrst_roundkey", roundKey, 128'(0));
    pulse_replay();
    repeat (4) begin
      chk("replay_after_rst", 128'(rkValid), 128'(0));
      @(posedge clock); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
